// File: rtl/l2_pkg.sv
// Shared L2 eviction-path definitions: line geometry, buffer entry layout
// and address helpers.
package l2_pkg;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = ADDR_W - OFFSET_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } ewb_entry_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        line_align = {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction
endpackage

// File: rtl/ewb_tag_match.sv
// Tag comparator over the circular entry array; reports the youngest
// matching entry (greatest distance from head) as a one-hot.
module ewb_tag_match
    import l2_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [PTR_W-1:0]            head,
    input  logic [TAG_W-1:0]            probe,
    output logic [DEPTH-1:0]            match_oh,
    output logic                        any
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        match_oh = '0;
        any      = 1'b0;
        idx      = '0;
        for (int d = 0; d < DEPTH; d++) begin
            idx = head + PTR_W'(d);
            if (valid[idx] && (tags[idx] == probe)) begin
                match_oh      = '0;
                match_oh[idx] = 1'b1;
                any           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eviction_write_buffer_q.sv
// Multi-entry L2 eviction write buffer: FIFO drain to memory, read-hit
// forwarding of resident lines, and in-place coalescing of re-evictions.
module eviction_write_buffer_q
    import l2_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [LINE_W-1:0] hit_data,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp
);
    ewb_entry_t entries [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] cnt;

    logic [DEPTH-1:0]            valid_vec, push_valid;
    logic [DEPTH-1:0][TAG_W-1:0] tag_vec;
    logic [DEPTH-1:0]            lookup_oh, push_oh;
    logic                        lookup_any, push_any;
    logic                        pop, coalesce, alloc;
    ewb_entry_t                  head_e;

    logic unused_offset_bits;
    assign unused_offset_bits = ^{push_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0]};

    always_comb begin
        valid_vec = '0;
        tag_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            tag_vec[i]   = entries[i].tag;
        end
    end

    // The head may already be sampled by memory, so it is never a coalesce target.
    assign push_valid = valid_vec & ~(DEPTH'(1) << head);

    ewb_tag_match #(.DEPTH(DEPTH)) u_lookup_match (
        .valid    (valid_vec),
        .tags     (tag_vec),
        .head     (head),
        .probe    (lookup_addr[ADDR_W-1:OFFSET_W]),
        .match_oh (lookup_oh),
        .any      (lookup_any)
    );

    ewb_tag_match #(.DEPTH(DEPTH)) u_push_match (
        .valid    (push_valid),
        .tags     (tag_vec),
        .head     (head),
        .probe    (push_addr[ADDR_W-1:OFFSET_W]),
        .match_oh (push_oh),
        .any      (push_any)
    );

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lookup_oh[i]) hit_data = hit_data | entries[i].data;
        end
    end

    assign hit    = lookup_any;
    assign head_e = entries[head];

    assign pmem_write   = head_e.valid;
    assign pmem_address = pmem_write ? line_align({head_e.tag, {OFFSET_W{1'b0}}}) : '0;
    assign pmem_wdata   = pmem_write ? head_e.data : '0;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Full is judged on current state: a same-cycle pop never frees a slot.
    assign pop      = pmem_write & pmem_resp;
    assign coalesce = push & push_any;
    assign alloc    = push & ~push_any & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (coalesce && push_oh[i]) entries[i].data <= push_data;
            end
            if (alloc) begin
                entries[tail].valid <= 1'b1;
                entries[tail].tag   <= push_addr[ADDR_W-1:OFFSET_W];
                entries[tail].data  <= push_data;
                tail                <= tail + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(alloc) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_eviction_write_buffer_q.sv
// Directed self-checking bench for eviction_write_buffer_q with DEPTH=4.
module tb_eviction_write_buffer_q;
    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic [31:0]  push_addr;
    logic [255:0] push_data;
    logic         full, empty;
    logic [2:0]   count;
    logic [31:0]  lookup_addr;
    logic         hit;
    logic [255:0] hit_data;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eviction_write_buffer_q #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_addr    (push_addr),
        .push_data    (push_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .lookup_addr  (lookup_addr),
        .hit          (hit),
        .hit_data     (hit_data),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp)
    );

    function automatic logic [255:0] mk(input logic [31:0] s);
        mk = {8{s}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] a, input logic [255:0] d);
        push = 1'b1; push_addr = a; push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic pop_one();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lookup_addr = 32'h1000;
        tick();
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b exp 0", pmem_write); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b exp 0", hit); end
        checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address: got %h exp 0", pmem_address); end
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty: got %b exp 1", empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) push_line(32'h100 * (i + 1), mk(32'hA000_0000 + i + 1));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", count); end
        push_line(32'h500, mk(32'hA000_0005));
        lookup_addr = 32'h500;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count: got %0d exp 4", count); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL drop_hit: got %b exp 0", hit); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL drain_write[%0d]: got %b exp 1", i, pmem_write); end
            checks++; if (pmem_address !== 32'h100 * (i + 1)) begin errors++; $display("FAIL drain_addr[%0d]: got %h exp %h", i, pmem_address, 32'h100 * (i + 1)); end
            checks++; if (pmem_wdata !== mk(32'hA000_0000 + i + 1)) begin errors++; $display("FAIL drain_data[%0d]: got %h", i, pmem_wdata); end
            pop_one();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b exp 1", empty); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL drained_write: got %b exp 0", pmem_write); end
        push_line(32'h600, mk(32'hA000_0006));
        checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL wrap_write: got %b exp 1", pmem_write); end
        checks++; if (pmem_address !== 32'h600) begin errors++; $display("FAIL wrap_addr: got %h exp 600", pmem_address); end
        checks++; if (pmem_wdata !== mk(32'hA000_0006)) begin errors++; $display("FAIL wrap_data: got %h", pmem_wdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count: got %0d exp 1", count); end
        pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b exp 1", empty); end
    endtask

    task automatic test_hit();
        push_line(32'h2A0, mk(32'hD1D1_0001));
        lookup_addr = 32'h2BF;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b exp 1", hit); end
        checks++; if (hit_data !== mk(32'hD1D1_0001)) begin errors++; $display("FAIL hit_data: got %h", hit_data); end
        lookup_addr = 32'h2C0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_neighbour: got %b exp 0", hit); end
        lookup_addr = 32'h2BF;
        pop_one();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_after_pop: got %b exp 0", hit); end
        checks++; if (hit_data !== 256'h0) begin errors++; $display("FAIL hit_data_after_pop: got %h exp 0", hit_data); end
    endtask

    task automatic test_coalesce();
        push_line(32'h100, mk(32'hC0C0_00A0));
        push_line(32'h200, mk(32'hC0C0_00D1));
        push_line(32'h200, mk(32'hC0C0_00D2));
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL coal_count: got %0d exp 2", count); end
        lookup_addr = 32'h200;
        #1;
        checks++; if (hit_data !== mk(32'hC0C0_00D2)) begin errors++; $display("FAIL coal_lookup: got %h", hit_data); end
        push_line(32'h100, mk(32'hC0C0_00D3));
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL head_alloc_count: got %0d exp 3", count); end
        lookup_addr = 32'h100;
        #1;
        checks++; if (hit_data !== mk(32'hC0C0_00D3)) begin errors++; $display("FAIL youngest_lookup: got %h", hit_data); end
        checks++; if (pmem_wdata !== mk(32'hC0C0_00A0)) begin errors++; $display("FAIL head_stable: got %h", pmem_wdata); end
        pop_one();
        checks++; if (pmem_address !== 32'h200) begin errors++; $display("FAIL coal_drain_addr: got %h exp 200", pmem_address); end
        checks++; if (pmem_wdata !== mk(32'hC0C0_00D2)) begin errors++; $display("FAIL coal_drain_data: got %h", pmem_wdata); end
        pop_one();
        checks++; if (pmem_address !== 32'h100) begin errors++; $display("FAIL realloc_drain_addr: got %h exp 100", pmem_address); end
        checks++; if (pmem_wdata !== mk(32'hC0C0_00D3)) begin errors++; $display("FAIL realloc_drain_data: got %h", pmem_wdata); end
        pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coal_empty: got %b exp 1", empty); end
    endtask

    task automatic test_back_to_back();
        push_line(32'h1000, mk(32'hB000_0001));
        push_line(32'h1100, mk(32'hB000_0002));
        pmem_resp = 1'b1;
        push_line(32'h700, mk(32'hB000_0007));
        pmem_resp = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pushpop_count: got %0d exp 2", count); end
        checks++; if (pmem_address !== 32'h1100) begin errors++; $display("FAIL pushpop_head: got %h exp 1100", pmem_address); end
        push_line(32'h1200, mk(32'hB000_0003));
        push_line(32'h1300, mk(32'hB000_0004));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b exp 1", full); end
        pmem_resp = 1'b1;
        push_line(32'h800, mk(32'hB000_0008));
        pmem_resp = 1'b0;
        lookup_addr = 32'h800;
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d exp 3", count); end
        checks++; if (pmem_address !== 32'h700) begin errors++; $display("FAIL fullpop_head: got %h exp 700", pmem_address); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fullpop_dropped: got %b exp 0", hit); end
        for (int i = 0; i < 3; i++) pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pushpop_empty: got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        push_line(32'h3000, mk(32'hE000_0000));
        push_line(32'h3100, mk(32'hE000_0001));
        push_line(32'h3200, mk(32'hE000_0002));
        checks++; if (count !== 3'd3 || pmem_write !== 1'b1) begin errors++; $display("FAIL mid_pre: got count %0d write %b exp 3 1", count, pmem_write); end
        rst = 1'b1;
        pmem_resp = 1'b1;
        push_line(32'h3300, mk(32'hE000_0003));
        rst = 1'b0;
        pmem_resp = 1'b0;
        lookup_addr = 32'h3000;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_flags: got empty %b full %b exp 1 0", empty, full); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL mid_write: got %b exp 0", pmem_write); end
        checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h exp 0", pmem_address); end
        checks++; if (pmem_wdata !== 256'h0) begin errors++; $display("FAIL mid_wdata: got %h exp 0", pmem_wdata); end
        checks++; if (hit !== 1'b0 || hit_data !== 256'h0) begin errors++; $display("FAIL mid_hit: got %b %h exp 0 0", hit, hit_data); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_idle_count: got %0d exp 0", count); end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_addr = '0; push_data = '0;
        lookup_addr = 32'h1000; pmem_resp = 1'b0;
        test_reset();
        test_fill_drain();
        test_hit();
        test_coalesce();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
